// File: rtl/uart_frame_ctrl.sv
// Frame parser behind the UART receiver: HDR, LEN, payload, CHK -> buffered payload stream.
// Optional inter-byte timeout enabled by defining UART_FRAME_TOUT_EN.
module uart_frame_ctrl #(
  parameter int         CLK     = 50_000_000,
  parameter int         BPS     = 9600,
  parameter logic [7:0] HDR     = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         TOUT_B  = 3,
  localparam int        LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_vld,
  output logic [7:0]       frm_data,
  output logic             frm_vld,
  output logic             frm_last,
  input  logic             frm_rdy,
  output logic [LEN_W-1:0] frm_len,
  output logic             err_chk,
  output logic             err_len,
  output logic             err_tout,
  output logic             rx_drop,
  output logic             busy
);

  localparam int               PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int               DEPTH     = 1 << PTR_W;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = '0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       frm_data_q, frm_data_d;
  logic             frm_vld_q, frm_vld_d, frm_last_q, frm_last_d;
  logic             err_chk_q, err_chk_d, err_len_q, err_len_d;
  logic             err_tout_q, err_tout_d, rx_drop_q, rx_drop_d;
  logic             busy_q, busy_d;
  logic             mem_we, tout_hit;
  logic [PTR_W-1:0] last_idx, rd_nxt;
  logic [7:0]       mem_q [DEPTH];

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign last_idx = PTR_W'(len_q - LEN_ONE);
  assign rd_nxt   = rd_q + PTR_ONE;

`ifdef UART_FRAME_TOUT_EN
  localparam int              BYTE_CNT = 10 * CLK / BPS;
  localparam int              TOUT_CNT = TOUT_B * BYTE_CNT;
  localparam int              TC_W     = $clog2(TOUT_CNT + 1);
  localparam logic [TC_W-1:0] TC_LAST  = TC_W'(TOUT_CNT - 1);
  localparam logic [TC_W-1:0] TC_ONE   = TC_W'(1);

  logic [TC_W-1:0] tout_q, tout_d;
  logic            in_frame;

  // Idle-time counter; any received byte or leaving the frame states clears it.
  always_comb begin
    in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    tout_hit = in_frame && (tout_q == TC_LAST);
    if (in_frame && !rx_vld && !tout_hit) begin
      tout_d = tout_q + TC_ONE;
    end else begin
      tout_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout_q <= '0;
    end else begin
      tout_q <= tout_d;
    end
  end
`else
  assign tout_hit = 1'b0;
`endif

  // Next-state and next-output logic; a byte in the same cycle as terminal count wins.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    sum_d      = sum_q;
    frm_data_d = frm_data_q;
    frm_vld_d  = frm_vld_q;
    frm_last_d = frm_last_q;
    err_chk_d  = 1'b0;
    err_len_d  = 1'b0;
    err_tout_d = 1'b0;
    rx_drop_d  = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_vld && (rx_data == HDR)) begin
          state_d = S_LEN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (rx_vld) begin
          sum_d = rx_data;
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = rx_data[LEN_W-1:0];
            wr_d    = PTR_ZERO;
            state_d = S_DATA;
          end
        end else if (tout_hit) begin
          err_tout_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (rx_vld) begin
          mem_we = 1'b1;
          sum_d  = sum8(sum_q, rx_data);
          wr_d   = wr_q + PTR_ONE;
          if (wr_q == last_idx) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end else if (tout_hit) begin
          err_tout_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (rx_vld) begin
          if (rx_data == sum_q) begin
            rd_d       = PTR_ZERO;
            frm_vld_d  = 1'b1;
            frm_data_d = mem_q[PTR_ZERO];
            frm_last_d = (len_q == LEN_ONE);
            state_d    = S_OUT;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (tout_hit) begin
          err_tout_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_CHK;
        end
      end
      S_OUT: begin
        rx_drop_d = rx_vld;
        if (frm_vld_q && frm_rdy) begin
          if (frm_last_q) begin
            frm_vld_d  = 1'b0;
            frm_last_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            rd_d       = rd_nxt;
            frm_data_d = mem_q[rd_nxt];
            frm_last_d = (rd_nxt == last_idx);
            state_d    = S_OUT;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        frm_vld_d  = 1'b0;
        frm_last_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      sum_q      <= 8'd0;
      frm_data_q <= 8'd0;
      frm_vld_q  <= 1'b0;
      frm_last_q <= 1'b0;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_tout_q <= 1'b0;
      rx_drop_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      sum_q      <= sum_d;
      frm_data_q <= frm_data_d;
      frm_vld_q  <= frm_vld_d;
      frm_last_q <= frm_last_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_tout_q <= err_tout_d;
      rx_drop_q  <= rx_drop_d;
      busy_q     <= busy_d;
    end
  end

  // Payload buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_q] <= rx_data;
    end
  end

  assign frm_data = frm_data_q;
  assign frm_vld  = frm_vld_q;
  assign frm_last = frm_last_q;
  assign frm_len  = len_q;
  assign err_chk  = err_chk_q;
  assign err_len  = err_len_q;
  assign err_tout = err_tout_q;
  assign rx_drop  = rx_drop_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed frame scenarios plus randomized frames against a frame-level model.
module tb_uart_frame_ctrl;
  localparam int MAX_LEN  = 16;
  localparam int TOUT_CNT = 3 * (10 * 1_000_000 / 100_000);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_vld = 1'b0;
  logic       frm_rdy = 1'b0;
  logic [7:0] frm_data;
  logic       frm_vld, frm_last;
  logic [4:0] frm_len;
  logic       err_chk, err_len, err_tout, rx_drop, busy;
  logic [19:0] outs;

  int n_checks = 0, n_fail = 0;
  int n_echk = 0, n_elen = 0, n_etout = 0, n_drop = 0;
  int exp_echk = 0, exp_elen = 0, exp_etout = 0, exp_drop = 0;
  logic [4:0] exp_len = 5'd0;
  logic [8:0] got_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] pay[$];
  bit         rdy_rand = 1'b0;
  bit         hold_armed = 1'b0;
  logic [7:0] hold_data = 8'd0;
  logic       hold_last = 1'b0;

  uart_frame_ctrl #(.CLK(1_000_000), .BPS(100_000), .HDR(8'hA5), .MAX_LEN(MAX_LEN), .TOUT_B(3)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
    .frm_data(frm_data), .frm_vld(frm_vld), .frm_last(frm_last), .frm_rdy(frm_rdy),
    .frm_len(frm_len), .err_chk(err_chk), .err_len(err_len), .err_tout(err_tout),
    .rx_drop(rx_drop), .busy(busy)
  );

  assign outs = {frm_vld, frm_last, frm_data, frm_len, err_chk, err_len, err_tout, rx_drop, busy};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: collects handshaken bytes, counts pulse cycles, checks hold and frm_len.
  always @(negedge clk) begin
    if (rst) begin
      hold_armed = 1'b0;
    end else begin
      if (hold_armed) begin
        check("hold_vld", frm_vld, 1);
        check("hold_data", frm_data, hold_data);
        check("hold_last", frm_last, hold_last);
      end
      if (frm_vld) check("frm_len", frm_len, exp_len);
      if (frm_vld && frm_rdy) got_q.push_back({frm_last, frm_data});
      hold_armed = frm_vld && !frm_rdy;
      hold_data  = frm_data;
      hold_last  = frm_last;
      if (err_chk)  n_echk++;
      if (err_len)  n_elen++;
      if (err_tout) n_etout++;
      if (rx_drop)  n_drop++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) frm_rdy = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
  endtask

  task automatic send_tx(input int maxgap);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i > 0) repeat ($urandom_range(0, maxgap)) tick();
      send_byte(tx_q[i]);
    end
    tx_q.delete();
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // Frame model: checksum is LEN plus every payload byte, modulo 256.
  task automatic make_frame(input bit bad_chk);
    logic [7:0] s;
    s = 8'(pay.size());
    tx_q.push_back(8'hA5);
    tx_q.push_back(s);
    foreach (pay[i]) begin
      tx_q.push_back(pay[i]);
      s = s + pay[i];
    end
    if (bad_chk) s = s + 8'($urandom_range(1, 255));
    tx_q.push_back(s);
  endtask

  task automatic check_stream();
    logic lastb;
    check("stream_n", got_q.size(), pay.size());
    for (int i = 0; i < got_q.size() && i < pay.size(); i++) begin
      lastb = (i == pay.size() - 1);
      check("stream_byte", got_q[i], {lastb, pay[i]});
    end
  endtask

  task automatic check_counts();
    check("n_err_chk", n_echk, exp_echk);
    check("n_err_len", n_elen, exp_elen);
    check("n_err_tout", n_etout, exp_etout);
    check("n_rx_drop", n_drop, exp_drop);
  endtask

  task automatic wait_stream();
    int k = 0;
    while ((got_q.size() < pay.size() || busy) && k < 600) begin
      tick();
      k++;
    end
    check_stream();
    check("busy_after_stream", busy, 0);
  endtask

  initial begin
    int kind, n;
    logic [7:0] b;
    repeat (3) tick();
    check("reset_outs", outs, 0);
    rst = 1'b0;
    tick();

    // Basic good frame, always ready
    frm_rdy = 1'b1;
    pay = '{8'h11, 8'h22, 8'h33};
    exp_len = 5'd3;
    make_frame(1'b0);
    send_tx(0);
    check("t1_b0", {frm_vld, frm_last, frm_data}, {1'b1, 1'b0, 8'h11});
    tick();
    check("t1_b1", {frm_vld, frm_last, frm_data}, {1'b1, 1'b0, 8'h22});
    tick();
    check("t1_b2", {frm_vld, frm_last, frm_data, frm_len}, {1'b1, 1'b1, 8'h33, 5'd3});
    tick();
    check("t1_end", {frm_vld, busy}, 2'b00);
    got_q.delete();
    check_counts();

    // Checksum error
    tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_tx(0);
    check("t2_err", {err_chk, frm_vld}, 2'b10);
    exp_echk++;
    tick();
    check("t2_after", {err_chk, busy, frm_vld}, 3'b000);
    check_counts();

    // Length errors, second header arrives right as the FSM returns to idle
    tx_q = '{8'hA5, 8'h00, 8'hA5, 8'h11};
    send_tx(0);
    check("t3_err", {err_len, busy}, 2'b10);
    exp_elen += 2;
    tick();
    check("t3_after", {err_len, busy}, 2'b00);
    check_counts();

    // Inter-byte timeout
    tx_q = '{8'hA5, 8'h02, 8'h10};
    send_tx(0);
    repeat (TOUT_CNT - 50) tick();
    check("t4_busy_early", busy, 1);
    check("t4_tout_early", n_etout, 0);
    repeat (70) tick();
`ifdef UART_FRAME_TOUT_EN
    exp_etout++;
    check("t4_busy_after", busy, 0);
`else
    check("t4_busy_after", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif
    check_counts();

    // Backpressure with bytes dropped during streaming
    frm_rdy = 1'b1;
    pay = '{8'h5A, 8'hC3, 8'h0F};
    exp_len = 5'd3;
    got_q.delete();
    make_frame(1'b0);
    send_tx(1);
    check("t5_first", {frm_vld, frm_data}, {1'b1, 8'h5A});
    tick();
    frm_rdy = 1'b0;
    send_byte(8'h77);
    check("t5_drop1", {rx_drop, frm_data}, {1'b1, 8'hC3});
    send_byte(8'hA5);
    check("t5_drop2", {rx_drop, frm_data}, {1'b1, 8'hC3});
    frm_rdy = 1'b1;
    tick();
    tick();
    exp_drop += 2;
    check_stream();
    check("t5_idle", {frm_vld, busy}, 2'b00);
    check_counts();

    // Reset mid-DATA
    tx_q = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_tx(0);
    rst = 1'b1;
    #2;
    check("t6_rst_data", outs, 0);
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-OUT
    frm_rdy = 1'b0;
    got_q.delete();
    rand_pay(3);
    exp_len = 5'd3;
    make_frame(1'b0);
    send_tx(0);
    check("t6_in_out", frm_vld, 1);
    tick();
    tick();
    rst = 1'b1;
    #2;
    check("t6_rst_out", outs, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_partial", got_q.size(), 0);

    // Recovery frame, then randomized frames
    rdy_rand = 1'b1;
    rand_pay(5);
    exp_len = 5'd5;
    make_frame(1'b0);
    send_tx(2);
    wait_stream();
    got_q.delete();
    check_counts();

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      repeat ($urandom_range(0, 3)) tick();
      if (kind <= 6) begin
        n = (kind == 5) ? 1 : (kind == 6) ? MAX_LEN : $urandom_range(1, MAX_LEN);
        rand_pay(n);
        exp_len = 5'(n);
        make_frame(1'b0);
        send_tx(3);
        wait_stream();
      end else if (kind == 7) begin
        rand_pay($urandom_range(1, MAX_LEN));
        make_frame(1'b1);
        send_tx(3);
        tick();
        exp_echk++;
        check("rnd_no_stream", got_q.size(), 0);
      end else if (kind == 8) begin
        tx_q.push_back(8'hA5);
        tx_q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
        send_tx(3);
        tick();
        exp_elen++;
        check("rnd_no_stream", got_q.size(), 0);
      end else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b);
        tick();
        check("rnd_junk_idle", busy, 0);
      end
      got_q.delete();
      check_counts();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
